// File: rtl/bomb_status.sv
// -----------------------------------------------------------------------------
// bomb_status
//
// Central game-state keeper for the bomb. It tracks whether the bomb is idle,
// armed, defused (won) or detonated. It also counts strikes, records which
// puzzle modules are solved, and drives the strike indicator pulse.
//
// Parameters
//   NUM_MODULES  : number of puzzle-module channels (1..16)
//   MAX_STRIKES  : strike count that detonates the bomb (1..2^STRIKE_W-1)
//   STRIKE_W     : width of strike_count
//   FLASH_CYCLES : strike_flash pulse length in clocks (>=1)
//
// Ports
//   clock         in   single clock, rising-edge active
//   reset         in   synchronous, active-high reset
//   start         in   arm request, honoured only while idle
//   explode_timer in   countdown-expired level/pulse from the timer block
//   strike        in   [NUM_MODULES] per-module wrong-action pulses
//   solved        in   [NUM_MODULES] per-module solved pulses
//   armed         out  high while armed
//   game_over     out  high once exploded
//   game_won      out  high once every module is solved
//   strike_count  out  [STRIKE_W] accepted strikes, saturating at MAX_STRIKES
//   solved_mask   out  [NUM_MODULES] sticky record of solved modules
//   cause         out  [2] explosion cause: 00 none, 01 timer, 10 strikes
//   strike_flash  out  strike indicator pulse for display/buzzer
//   freeze_timer  out  high when won or exploded; halts the countdown
//
// All outputs come straight from flops. An input event sampled on edge n is
// visible on the outputs right after that edge.
// -----------------------------------------------------------------------------
module bomb_status #(
  parameter int NUM_MODULES  = 4,
  parameter int MAX_STRIKES  = 3,
  parameter int STRIKE_W     = 2,
  parameter int FLASH_CYCLES = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   explode_timer,
  input  logic [NUM_MODULES-1:0] strike,
  input  logic [NUM_MODULES-1:0] solved,
  output logic                   armed,
  output logic                   game_over,
  output logic                   game_won,
  output logic [STRIKE_W-1:0]    strike_count,
  output logic [NUM_MODULES-1:0] solved_mask,
  output logic [1:0]             cause,
  output logic                   strike_flash,
  output logic                   freeze_timer
);

  // The sum is computed wide enough to hold the old count plus up to 16
  // simultaneous strikes. Saturation therefore never depends on a wrapped value.
  localparam int CNT_W   = STRIKE_W + 5;
  localparam int FLASH_W = $clog2(FLASH_CYCLES + 1);

  localparam logic [CNT_W-1:0]    MAX_WIDE  = CNT_W'(MAX_STRIKES);
  localparam logic [STRIKE_W-1:0] MAX_COUNT = STRIKE_W'(MAX_STRIKES);
  localparam logic [FLASH_W-1:0]  FLASH_LEN = FLASH_W'(FLASH_CYCLES);

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_TIMER   = 2'b01;
  localparam logic [1:0] CAUSE_STRIKES = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_WON,
    S_EXPLODED
  } state_t;

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  state_t                 r_state;
  logic [STRIKE_W-1:0]    r_strike_count;
  logic [NUM_MODULES-1:0] r_solved_mask;
  logic [1:0]             r_cause;
  logic [FLASH_W-1:0]     r_flash_cnt;
  logic                   r_strike_flash;
  logic                   r_armed;
  logic                   r_game_over;
  logic                   r_game_won;
  logic                   r_freeze_timer;

  // ---------------------------------------------------------------------------
  // Next-state values
  // ---------------------------------------------------------------------------
  state_t                 w_state_next;
  logic [STRIKE_W-1:0]    w_count_next;
  logic [NUM_MODULES-1:0] w_mask_next;
  logic [1:0]             w_cause_next;
  logic [FLASH_W-1:0]     w_flash_cnt_next;
  logic [NUM_MODULES-1:0] w_accepted;
  logic [CNT_W-1:0]       w_popcount;
  logic [CNT_W-1:0]       w_sum;

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default before the case statement.
  // A path that skipped an assignment would otherwise infer a latch.
  always_comb begin
    w_state_next     = r_state;
    w_count_next     = r_strike_count;
    w_mask_next      = r_solved_mask;
    w_cause_next     = r_cause;
    w_flash_cnt_next = r_flash_cnt;
    w_accepted       = '0;
    w_popcount       = '0;
    w_sum            = '0;

    unique case (r_state)
      S_IDLE: begin
        // Strikes, solves and the timer mean nothing before the bomb is armed.
        if (start) begin
          w_state_next = S_ARMED;
        end
      end

      S_ARMED: begin
        w_mask_next = r_solved_mask | solved;

        // The mask after the update is used here. A module that solves and
        // strikes in the same cycle is therefore already safe, and its strike
        // is dropped.
        w_accepted = strike & ~w_mask_next;

        for (int i = 0; i < NUM_MODULES; i++) begin
          w_popcount = w_popcount + CNT_W'(w_accepted[i]);
        end

        w_sum = CNT_W'(r_strike_count) + w_popcount;
        if (w_sum >= MAX_WIDE) begin
          w_count_next = MAX_COUNT;
        end else begin
          w_count_next = w_sum[STRIKE_W-1:0];
        end

        // Any accepted strike reloads the full pulse length. The count then
        // runs down to zero, and the flash stays high while it is non-zero.
        if (|w_accepted) begin
          w_flash_cnt_next = FLASH_LEN;
        end else if (r_flash_cnt != '0) begin
          w_flash_cnt_next = r_flash_cnt - 1'b1;
        end

        // Explosion beats winning. The timer is named as the cause when it
        // coincides with the final strike.
        if (explode_timer) begin
          w_state_next     = S_EXPLODED;
          w_cause_next     = CAUSE_TIMER;
          w_flash_cnt_next = '0;
        end else if (w_count_next == MAX_COUNT) begin
          w_state_next     = S_EXPLODED;
          w_cause_next     = CAUSE_STRIKES;
          w_flash_cnt_next = '0;
        end else if (&w_mask_next) begin
          w_state_next     = S_WON;
          w_flash_cnt_next = '0;
        end
      end

      // WON and EXPLODED are terminal: every recorded value holds until reset.
      default: begin
        w_flash_cnt_next = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. Every flop then
  // samples its pre-edge inputs, whatever order the statements are written in.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_strike_count <= '0;
      r_solved_mask  <= '0;
      r_cause        <= CAUSE_NONE;
      r_flash_cnt    <= '0;
      r_strike_flash <= 1'b0;
      r_armed        <= 1'b0;
      r_game_over    <= 1'b0;
      r_game_won     <= 1'b0;
      r_freeze_timer <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_strike_count <= w_count_next;
      r_solved_mask  <= w_mask_next;
      r_cause        <= w_cause_next;
      r_flash_cnt    <= w_flash_cnt_next;
      r_strike_flash <= (w_flash_cnt_next != '0);
      r_armed        <= (w_state_next == S_ARMED);
      r_game_over    <= (w_state_next == S_EXPLODED);
      r_game_won     <= (w_state_next == S_WON);
      r_freeze_timer <= (w_state_next == S_WON) || (w_state_next == S_EXPLODED);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign armed        = r_armed;
  assign game_over    = r_game_over;
  assign game_won     = r_game_won;
  assign strike_count = r_strike_count;
  assign solved_mask  = r_solved_mask;
  assign cause        = r_cause;
  assign strike_flash = r_strike_flash;
  assign freeze_timer = r_freeze_timer;

endmodule

// File: tb/tb_bomb_status.sv
// -----------------------------------------------------------------------------
// tb_bomb_status
//
// Directed stimulus for bomb_status with default parameters (4 modules,
// 3 strikes, 16-cycle flash). Each stimulus cycle pushes its hand-computed
// expected output snapshot into a scoreboard queue, tagged with the cycle in
// which it must appear. A separate monitor samples the DUT on the falling edge
// and compares against the queue head.
//
// Snapshot packing: {armed, game_over, game_won, strike_count[1:0],
//                    solved_mask[3:0], cause[1:0], strike_flash, freeze_timer}
// -----------------------------------------------------------------------------
module tb_bomb_status;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       explode_timer;
  logic [3:0] strike;
  logic [3:0] solved;
  logic       armed;
  logic       game_over;
  logic       game_won;
  logic [1:0] strike_count;
  logic [3:0] solved_mask;
  logic [1:0] cause;
  logic       strike_flash;
  logic       freeze_timer;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    string       name;
    int          tcyc;
    logic [12:0] v;
  } exp_t;

  exp_t sb[$];

  bomb_status #(
    .NUM_MODULES (4),
    .MAX_STRIKES (3),
    .STRIKE_W    (2),
    .FLASH_CYCLES(16)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .explode_timer(explode_timer),
    .strike       (strike),
    .solved       (solved),
    .armed        (armed),
    .game_over    (game_over),
    .game_won     (game_won),
    .strike_count (strike_count),
    .solved_mask  (solved_mask),
    .cause        (cause),
    .strike_flash (strike_flash),
    .freeze_timer (freeze_timer)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: compares the queue head once its target cycle arrives.
  always @(negedge clock) begin
    logic [12:0] act;
    act = {armed, game_over, game_won, strike_count, solved_mask, cause,
           strike_flash, freeze_timer};
    while (sb.size() > 0 && sb[0].tcyc <= cyc) begin
      checks++;
      if (sb[0].tcyc < cyc) begin
        failures++;
        $display("FAIL %s: expected at cycle %0d, not sampled (now %0d)",
                 sb[0].name, sb[0].tcyc, cyc);
      end else if (act !== sb[0].v) begin
        failures++;
        $display("FAIL %s: got a/o/w/sc/mask/cause/fl/fz=%b_%b_%b_%b_%b_%b_%b_%b want %b_%b_%b_%b_%b_%b_%b_%b",
                 sb[0].name, act[12], act[11], act[10], act[9:8], act[7:4], act[3:2], act[1], act[0],
                 sb[0].v[12], sb[0].v[11], sb[0].v[10], sb[0].v[9:8], sb[0].v[7:4],
                 sb[0].v[3:2], sb[0].v[1], sb[0].v[0]);
      end
      void'(sb.pop_front());
    end
  end

  // Drives one cycle of inputs and queues the snapshot expected after the edge.
  task automatic step(input int rs, input int st, input int tm, input int sk,
                      input int sv, input string nm, input int ea, input int eo,
                      input int ew, input int esc, input int em, input int ec,
                      input int efl);
    exp_t e;
    reset         = 1'(rs);
    start         = 1'(st);
    explode_timer = 1'(tm);
    strike        = 4'(sk);
    solved        = 4'(sv);
    e.name = nm;
    e.tcyc = cyc + 1;
    e.v    = {1'(ea), 1'(eo), 1'(ew), 2'(esc), 4'(em), 2'(ec), 1'(efl),
              1'(eo) | 1'(ew)};
    sb.push_back(e);
    @(posedge clock);
    #1;
    reset         = 1'b0;
    start         = 1'b0;
    explode_timer = 1'b0;
    strike        = 4'h0;
    solved        = 4'h0;
  endtask

  task automatic do_reset(input string nm);
    step(1, 0, 0, 0, 0, nm, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_arm(input string nm);
    step(0, 1, 0, 0, 0, nm, 1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; explode_timer = 1'b0; strike = 4'h0; solved = 4'h0;
    @(posedge clock);
    #1;

    //   rs st tm sk    sv    name                   a  o  w  sc mask  c  fl
    // --- Three separate strikes detonate; terminal state ignores inputs
    do_reset("s1_reset");
    step(0, 0, 1, 4'h1, 4'hF, "s1_idle_ignores", 0, 0, 0, 0, 4'h0, 0, 0);
    step(0, 1, 0, 4'h1, 4'h0, "s1_start_no_strk", 1, 0, 0, 0, 4'h0, 0, 0);
    step(0, 0, 0, 4'h1, 4'h0, "s1_strike1",       1, 0, 0, 1, 4'h0, 0, 1);
    step(0, 0, 0, 4'h0, 4'h0, "s1_gap",           1, 0, 0, 1, 4'h0, 0, 1);
    step(0, 0, 0, 4'h1, 4'h0, "s1_strike2",       1, 0, 0, 2, 4'h0, 0, 1);
    step(0, 1, 0, 4'h0, 4'h0, "s1_start_armed",   1, 0, 0, 2, 4'h0, 0, 1);
    step(0, 0, 0, 4'h1, 4'h0, "s1_strike3_boom",  0, 1, 0, 3, 4'h0, 2, 0);
    step(0, 1, 1, 4'hF, 4'hF, "s1_frozen",        0, 1, 0, 3, 4'h0, 2, 0);

    // --- Three simultaneous strikes all count
    do_reset("s2_reset");
    do_arm("s2_arm");
    step(0, 0, 0, 4'h7, 4'h0, "s2_multi_strike",  0, 1, 0, 3, 4'h0, 2, 0);

    // --- All solved wins; later timer is ignored
    do_reset("s3_reset");
    do_arm("s3_arm");
    step(0, 0, 0, 4'h0, 4'h1, "s3_solve0",        1, 0, 0, 0, 4'h1, 0, 0);
    step(0, 0, 0, 4'h0, 4'h2, "s3_solve1",        1, 0, 0, 0, 4'h3, 0, 0);
    step(0, 0, 0, 4'h0, 4'hC, "s3_solve23_win",   0, 0, 1, 0, 4'hF, 0, 0);
    step(0, 0, 1, 4'h0, 4'h0, "s3_timer_ignored", 0, 0, 1, 0, 4'hF, 0, 0);
    step(0, 1, 0, 4'hF, 4'h0, "s3_won_frozen",    0, 0, 1, 0, 4'hF, 0, 0);

    // --- Timer beats a simultaneous final solve
    do_reset("s4_reset");
    do_arm("s4_arm");
    step(0, 0, 0, 4'h0, 4'h7, "s4_solve012",      1, 0, 0, 0, 4'h7, 0, 0);
    step(0, 0, 0, 4'h8, 4'h0, "s4_strike3a",      1, 0, 0, 1, 4'h7, 0, 1);
    step(0, 0, 0, 4'h8, 4'h0, "s4_strike3b",      1, 0, 0, 2, 4'h7, 0, 1);
    step(0, 0, 1, 4'h0, 4'h8, "s4_timer_vs_win",  0, 1, 0, 2, 4'hF, 1, 0);

    // --- Flash restart and length; strikes on solved modules are ignored
    do_reset("s5_reset");
    do_arm("s5_arm");
    step(0, 0, 0, 4'h2, 4'h0, "s5_strike_t",      1, 0, 0, 1, 4'h0, 0, 1);
    for (int i = 0; i < 4; i++)
      step(0, 0, 0, 4'h0, 4'h0, "s5_flash_a",     1, 0, 0, 1, 4'h0, 0, 1);
    step(0, 0, 0, 4'h2, 4'h0, "s5_strike_t5",     1, 0, 0, 2, 4'h0, 0, 1);
    step(0, 0, 0, 4'h0, 4'h4, "s5_solve2",        1, 0, 0, 2, 4'h4, 0, 1);
    step(0, 0, 0, 4'h4, 4'h0, "s5_strike_solved", 1, 0, 0, 2, 4'h4, 0, 1);
    step(0, 0, 0, 4'h1, 4'h1, "s5_same_cyc_solve",1, 0, 0, 2, 4'h5, 0, 1);
    for (int i = 0; i < 12; i++)
      step(0, 0, 0, 4'h0, 4'h0, "s5_flash_b",     1, 0, 0, 2, 4'h5, 0, 1);
    step(0, 0, 0, 4'h0, 4'h0, "s5_flash_end",     1, 0, 0, 2, 4'h5, 0, 0);

    // --- Reset from EXPLODED and mid-flash; reset beats start
    step(0, 0, 0, 4'h2, 4'h0, "s6_boom",          0, 1, 0, 3, 4'h5, 2, 0);
    do_reset("s6_reset_exploded");
    do_arm("s6_rearm");
    step(0, 0, 0, 4'h1, 4'h0, "s6_strike",        1, 0, 0, 1, 4'h0, 0, 1);
    step(0, 0, 0, 4'h0, 4'h0, "s6_midflash",      1, 0, 0, 1, 4'h0, 0, 1);
    do_reset("s6_reset_midflash");
    step(1, 1, 1, 4'hF, 4'hF, "s6_reset_priority",0, 0, 0, 0, 4'h0, 0, 0);
    do_arm("s6_rearm2");
    step(0, 0, 1, 4'h1, 4'h0, "s6_timer_w_strike",0, 1, 0, 1, 4'h0, 1, 0);

    // --- Strike sum past the limit saturates
    do_reset("s7_reset");
    do_arm("s7_arm");
    step(0, 0, 0, 4'h1, 4'h0, "s7_strike1",       1, 0, 0, 1, 4'h0, 0, 1);
    step(0, 0, 0, 4'hE, 4'h0, "s7_saturate",      0, 1, 0, 3, 4'h0, 2, 0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clock);
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expected snapshots never compared", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bomb_status.md
BOMB_STATUS -- requirements
Module: bomb_status

Interface
REQ-001 Parameter NUM_MODULES, default 4: number of puzzle-module channels (1..16).
REQ-002 Parameter MAX_STRIKES, default 3: strike count that detonates the bomb (1..2^STRIKE_W-1).
REQ-003 Parameter STRIKE_W, default 2: width of strike_count.
REQ-004 Parameter FLASH_CYCLES, default 16: strike_flash pulse length in clocks (>=1).
REQ-005 clock  in  1  single clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  arm request; acted on only in IDLE.
REQ-008 explode_timer  in  1  countdown-expired level or pulse from the timer block.
REQ-009 strike  in  NUM_MODULES  per-module one-cycle wrong-action pulses.
REQ-010 solved  in  NUM_MODULES  per-module one-cycle solved pulses.
REQ-011 armed  out  1  high while in ARMED.
REQ-012 game_over  out  1  high in EXPLODED.
REQ-013 game_won  out  1  high in WON.
REQ-014 strike_count  out  STRIKE_W  accepted strikes, saturating at MAX_STRIKES.
REQ-015 solved_mask  out  NUM_MODULES  sticky record of solved modules.
REQ-016 cause  out  2  00 none, 01 timer, 10 strikes.
REQ-017 strike_flash  out  1  strike indicator pulse for display/buzzer.
REQ-018 freeze_timer  out  1  high in WON or EXPLODED; halts the countdown.

Function
REQ-019 The block SHALL implement states IDLE, ARMED, WON, EXPLODED; all outputs registered; an input event in cycle n is visible on outputs from cycle n+1.
REQ-020 IDLE -> ARMED when start=1; in IDLE strike, solved and explode_timer SHALL be ignored.
REQ-021 In ARMED, accepted strikes = strike AND NOT solved_mask (post-update mask excluded: a module's strike in the same cycle as its own solve is ignored).
REQ-022 strike_count SHALL add the popcount of accepted strikes per cycle, saturating at MAX_STRIKES (multiple simultaneous strikes all count).
REQ-023 solved_mask SHALL be updated as solved_mask OR solved each cycle in ARMED.
REQ-024 ARMED -> EXPLODED with cause=01 when explode_timer=1.
REQ-025 ARMED -> EXPLODED with cause=10 when the updated strike_count reaches MAX_STRIKES and explode_timer=0.
REQ-026 ARMED -> WON when the updated solved_mask is all ones and neither REQ-024 nor REQ-025 fires; explosion SHALL take priority over win in the same cycle.
REQ-027 WON and EXPLODED SHALL be terminal until reset: start, strike, solved, explode_timer ignored; strike_count, solved_mask, cause frozen.
REQ-028 start while ARMED, WON or EXPLODED SHALL have no effect.
REQ-029 strike_flash SHALL go high the cycle after any cycle with >=1 accepted strike and remain high for exactly FLASH_CYCLES cycles; a new accepted strike while high SHALL restart the full count.
REQ-030 strike_flash SHALL be forced low and its counter cleared on entry to WON or EXPLODED.
REQ-031 Accepted strikes in the transition cycle to EXPLODED SHALL still update strike_count (saturated).

Reset
REQ-032 reset=1 at a rising edge SHALL, from any state including mid-flash, give: state IDLE, armed=0, game_over=0, game_won=0, strike_count=0, solved_mask=0, cause=00, strike_flash=0, freeze_timer=0.
REQ-033 reset SHALL take priority over every other input in the same cycle.

Verification
REQ-034 Defaults; start; strike[0] pulses in three separate cycles -> strike_count 1,2,3; game_over=1, cause=10, freeze_timer=1 the cycle after the third.
REQ-035 Armed; strike=4'b0111 in one cycle -> strike_count=3, game_over=1, cause=10 next cycle; strike_flash=0.
REQ-036 Armed; solved pulses for modules 0..3 -> game_won=1, solved_mask=4'hF; later explode_timer=1 -> still game_won=1, game_over=0.
REQ-037 Armed, solved_mask=4'h7, strike_count=2; solved[3]=1, explode_timer=1 same cycle -> game_over=1, cause=01, game_won=0.
REQ-038 Armed; strike[1] at cycle t, again at t+5 -> strike_flash high t+1..t+5+FLASH_CYCLES; solved[2] then strike[2] -> strike_count unchanged.
REQ-039 From EXPLODED and mid-flash, assert reset one cycle -> all outputs at REQ-032 values; start rearms with strike_count=0.
